// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment scan path: strobe codes,
// segment decode table, scan FSM encoding and the synchronized bus payload.
// Used by both the display driver and the scan decoder.
package seg7_scan_decoder_pkg;

  localparam int unsigned AN_W    = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned NUM_POS = 4;
  localparam int unsigned POS_W   = 2;

  // Active-low anode strobes, one per digit position
  localparam logic [AN_W-1:0] AN_A = 4'b0111;
  localparam logic [AN_W-1:0] AN_B = 4'b1011;
  localparam logic [AN_W-1:0] AN_C = 4'b1101;
  localparam logic [AN_W-1:0] AN_D = 4'b1110;

  // Active-low segments, bit 6 = a ... bit 0 = g
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;
  } scan_pair_t;

  typedef struct packed {
    logic             ok;
    logic [POS_W-1:0] pos;
  } strobe_t;

  // Map an anode strobe to its digit position; ok=0 for none or several low
  function automatic strobe_t strobe_decode(input logic [AN_W-1:0] an);
    strobe_t s;
    s.ok  = 1'b1;
    s.pos = '0;
    case (an)
      AN_A:    s.pos = 2'd0;
      AN_B:    s.pos = 2'd1;
      AN_C:    s.pos = 2'd2;
      AN_D:    s.pos = 2'd3;
      default: s.ok  = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_to_bcd.sv
// Combinational segment-pattern to BCD decode.
// Ports: i_seg (active-low segments), o_digit_c (BCD value), o_ok_c (pattern is a digit).
module seg7_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [BCD_W-1:0] o_digit_c,
  output logic             o_ok_c
);

  always_comb begin
    o_digit_c = '0;
    o_ok_c    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i_seg == SEG_TABLE[i]) begin
        o_digit_c = BCD_W'(i);
        o_ok_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers four BCD digits from a multiplexed 7-segment display bus.
// Ports: clk, rst_n (sync, active-low); an/display (scanned display inputs);
// A..D (last committed digits); valid (frame fresh within TIMEOUT);
// frame_done (commit pulse); err (last complete frame had a bad pattern).
module seg7_scan_decoder #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [6:0] display,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic       valid,
  output logic       frame_done,
  output logic       err
);
  import seg7_scan_decoder_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);
  // Counter parks one past the expiry point so the expiry acts exactly once
  localparam logic [TO_W-1:0]  TO_PARK     = TO_W'(TIMEOUT);

  scan_pair_t                    r_sync1, r_sync2, r_prev;
  scan_state_e                   r_state, w_state_nxt;
  logic [CNT_W-1:0]              r_settle_cnt, w_settle_cnt_nxt;
  logic [TO_W-1:0]               r_to_cnt;
  logic [NUM_POS-1:0]            r_seen, r_bad, w_seen_nxt, w_bad_nxt;
  logic [NUM_POS-1:0][BCD_W-1:0] r_shadow;

  logic       w_change, w_sample, w_dec_ok, w_commit, w_discard, w_timeout;
  logic [BCD_W-1:0] w_digit;
  strobe_t    w_strobe;

  assign w_change  = (r_sync2 != r_prev);
  assign w_strobe  = strobe_decode(r_sync2.an);
  assign w_commit  = (&r_seen) && !(|r_bad);
  assign w_discard = (&(r_seen | r_bad)) && (|r_bad);
  assign w_timeout = (r_to_cnt == TO_LAST);

  seg7_to_bcd u_to_bcd (
    .i_seg     (r_sync2.seg),
    .o_digit_c (w_digit),
    .o_ok_c    (w_dec_ok)
  );

  // Scan FSM next-state: any change restarts settling, illegal strobe parks in WAIT
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_sample         = 1'b0;
    if (w_change) begin
      w_state_nxt      = ST_SETTLE;
      w_settle_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (!w_strobe.ok) begin
            w_state_nxt = ST_WAIT;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            w_sample    = 1'b1;
            w_state_nxt = ST_HELD;
          end else begin
            w_settle_cnt_nxt = r_settle_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Frame bookkeeping: clear on commit/discard/expiry, then record a new sample
  always_comb begin
    w_seen_nxt = r_seen;
    w_bad_nxt  = r_bad;
    if (w_commit || w_discard || w_timeout) begin
      w_seen_nxt = '0;
      w_bad_nxt  = '0;
    end
    if (w_sample) begin
      if (w_dec_ok) w_seen_nxt[w_strobe.pos] = 1'b1;
      else          w_bad_nxt[w_strobe.pos]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1      <= '{an: '1, seg: SEG_BLANK};
      r_sync2      <= '{an: '1, seg: SEG_BLANK};
      r_prev       <= '{an: '1, seg: SEG_BLANK};
      r_state      <= ST_WAIT;
      r_settle_cnt <= '0;
      r_to_cnt     <= '0;
      r_seen       <= '0;
      r_bad        <= '0;
      r_shadow     <= '0;
      A            <= '0;
      B            <= '0;
      C            <= '0;
      D            <= '0;
      valid        <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      r_sync1      <= '{an: an, seg: display};
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_seen       <= w_seen_nxt;
      r_bad        <= w_bad_nxt;
      frame_done   <= w_commit;
      if (w_sample && w_dec_ok) r_shadow[w_strobe.pos] <= w_digit;
      if (w_commit) begin
        A        <= r_shadow[0];
        B        <= r_shadow[1];
        C        <= r_shadow[2];
        D        <= r_shadow[3];
        valid    <= 1'b1;
        err      <= 1'b0;
        r_to_cnt <= '0;
      end else begin
        if (w_discard) err <= 1'b1;
        if (w_timeout) valid <= 1'b0;
        if (r_to_cnt != TO_PARK) r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans digit frames onto the bus and
// checks the committed digits, valid/err flags, frame pulses and timeout.
module tb_seg7_scan_decoder;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 256;

  logic       clk;
  logic       rst_n;
  logic [3:0] an;
  logic [6:0] display;
  logic [3:0] A, B, C, D;
  logic       valid, frame_done, err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fd_count = 0;
  int fd_cycle = -1;
  int vfall_cycle = -1;
  logic valid_q = 1'b0;

  seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an         (an),
    .display    (display),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .valid      (valid),
    .frame_done (frame_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record frame pulses and the falling edge of valid, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_count <= fd_count + 1;
      fd_cycle <= cyc;
    end
    if (valid_q === 1'b1 && valid === 1'b0) vfall_cycle <= cyc;
    valid_q <= valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an      = a;
    display = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(4'b1111, 7'b1111111, n);
  endtask

  task automatic frame_seg(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input int n);
    drive(4'b0111, s0, n);
    drive(4'b1011, s1, n);
    drive(4'b1101, s2, n);
    drive(4'b1110, s3, n);
  endtask

  task automatic frame(input int d0, input int d1, input int d2, input int d3, input int n);
    frame_seg(seg_of(d0), seg_of(d1), seg_of(d2), seg_of(d3), n);
  endtask

  initial begin
    rst_n   = 1'b0;
    an      = 4'b1111;
    display = 7'b1111111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_digits", {16'h0, A, B, C, D}, 32'h0);
    check_eq("reset_valid", 32'(valid), 32'h0);
    check_eq("reset_frame_done", 32'(frame_done), 32'h0);
    check_eq("reset_err", 32'(err), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Digits held too briefly never settle
    frame(1, 2, 3, 4, 3);
    idle(10);
    @(negedge clk);
    check_eq("short_hold_no_frame", 32'(fd_count), 32'd0);
    check_eq("short_hold_valid", 32'(valid), 32'h0);
    check_eq("short_hold_err", 32'(err), 32'h0);

    // Basic frame 1,2,3,4
    frame(1, 2, 3, 4, 8);
    idle(4);
    @(negedge clk);
    check_eq("frame1234_count", 32'(fd_count), 32'd1);
    check_eq("frame1234_digits", {16'h0, A, B, C, D}, 32'h1234);
    check_eq("frame1234_valid", 32'(valid), 32'h1);
    check_eq("frame1234_err", 32'(err), 32'h0);

    // Blank pattern on C rejects the frame and keeps the old digits
    frame_seg(seg_of(9), seg_of(8), 7'b1111111, seg_of(7), 8);
    idle(4);
    @(negedge clk);
    check_eq("bad_frame_err", 32'(err), 32'h1);
    check_eq("bad_frame_digits", {16'h0, A, B, C, D}, 32'h1234);
    check_eq("bad_frame_no_commit", 32'(fd_count), 32'd1);
    check_eq("bad_frame_valid", 32'(valid), 32'h1);

    frame(5, 6, 7, 8, 8);
    idle(4);
    @(negedge clk);
    check_eq("recover_err", 32'(err), 32'h0);
    check_eq("recover_digits", {16'h0, A, B, C, D}, 32'h5678);
    check_eq("recover_count", 32'(fd_count), 32'd2);

    // Two strobes low for a while between digits is ignored
    drive(4'b0111, seg_of(9), 8);
    drive(4'b0011, seg_of(2), 20);
    drive(4'b1011, seg_of(0), 8);
    drive(4'b1101, seg_of(1), 8);
    drive(4'b1110, seg_of(2), 8);
    idle(4);
    @(negedge clk);
    check_eq("multi_strobe_digits", {16'h0, A, B, C, D}, 32'h9012);
    check_eq("multi_strobe_count", 32'(fd_count), 32'd3);

    // Idle bus: valid drops exactly TIMEOUT cycles after the last commit
    idle(TIMEOUT - 20);
    @(negedge clk);
    check_eq("before_timeout_valid", 32'(valid), 32'h1);
    idle(40);
    @(negedge clk);
    check_eq("after_timeout_valid", 32'(valid), 32'h0);
    check_eq("timeout_latency", 32'(vfall_cycle - fd_cycle), 32'(TIMEOUT));
    check_eq("timeout_digits_held", {16'h0, A, B, C, D}, 32'h9012);

    // Reset after two digits discards them
    drive(4'b0111, seg_of(3), 8);
    drive(4'b1011, seg_of(4), 8);
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    check_eq("midreset_digits", {16'h0, A, B, C, D}, 32'h0);
    check_eq("midreset_valid", 32'(valid), 32'h0);
    check_eq("midreset_err", 32'(err), 32'h0);
    check_eq("midreset_frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    idle(2);
    drive(4'b1101, seg_of(5), 8);
    drive(4'b1110, seg_of(6), 8);
    idle(4);
    @(negedge clk);
    check_eq("post_reset_partial_count", 32'(fd_count), 32'd3);
    check_eq("post_reset_partial_valid", 32'(valid), 32'h0);
    drive(4'b0111, seg_of(7), 8);
    drive(4'b1011, seg_of(8), 8);
    idle(4);
    @(negedge clk);
    check_eq("post_reset_count", 32'(fd_count), 32'd4);
    check_eq("post_reset_digits", {16'h0, A, B, C, D}, 32'h7856);
    check_eq("post_reset_valid", 32'(valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: cycles a synchronized {an,display} pair must stay unchanged before it is sampled (range 1..255).
REQ-002 Parameter TIMEOUT, default 65536: cycles without a committed frame before valid drops (range 16..2^24).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 an  input  4  multiplexed anode strobes, active-low; 0111=digit A, 1011=B, 1101=C, 1110=D.
REQ-006 display  input  7  segment bus, active-low, display[6]=a ... display[0]=g.
REQ-007 A, B, C, D  output  4 each  last committed BCD digits.
REQ-008 valid  output  1  high while A..D hold a frame committed within TIMEOUT.
REQ-009 frame_done  output  1  one-cycle pulse on each commit.
REQ-010 err  output  1  high after a frame is rejected for an undecodable pattern; cleared on the next commit.

Function
REQ-011 an and display SHALL pass through a 2-flop synchronizer; all further logic uses the synchronized values, giving 2 cycles input latency.
REQ-012 Scan FSM states: WAIT (pair changing), SETTLE (counting), HELD (sampled, waiting for change).
REQ-013 Any change of the synchronized pair SHALL move the FSM to SETTLE with the counter at 0, from any state.
REQ-014 In SETTLE the counter SHALL increment each cycle the pair is unchanged; on reaching SETTLE-1 the pair is sampled once and the FSM enters HELD.
REQ-015 An illegal strobe (no bit low or more than one low) SHALL send the FSM to WAIT without sampling; WAIT exits only on a pair change.
REQ-016 Sampling decodes display: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; every other pattern is undecodable.
REQ-017 A decoded sample SHALL be written to the shadow register of the strobed position and set that position's seen bit; an undecodable sample SHALL set that position's bad bit.
REQ-018 When all four seen bits are set and no bad bit is set, the shadow registers SHALL be copied to A..D on the next cycle, frame_done pulses, valid=1, err=0, and the seen/bad bits clear.
REQ-019 When all four positions are seen (or marked bad) and any bad bit is set, the frame SHALL be discarded, A..D are held, err=1, and the seen/bad bits clear.
REQ-020 Re-sampling an already-seen position before the frame completes SHALL overwrite its shadow value (newest wins).
REQ-021 The timeout counter SHALL reset on each commit, otherwise increment; when it reaches TIMEOUT-1, valid=0 and the seen/bad bits clear, and the counter saturates.
REQ-022 A commit and a timeout in the same cycle: the commit wins.

Reset
REQ-023 While rst_n=0 at a clock edge: A..D=0, valid=0, frame_done=0, err=0, FSM=WAIT, all counters, seen and bad bits 0, and synchronizer flops 1111/1111111 (blank).
REQ-024 A reset mid-frame SHALL discard the partial frame; the first commit after reset requires four fresh samples.

Structure
REQ-025 Segment decode table, strobe codes and FSM state encodings SHALL live in a shared package shared with the display driver.
REQ-026 The pattern-to-BCD decode SHALL be one combinational sub-module, seg7_to_bcd (7-bit in, 4-bit digit plus ok flag).

Verification
REQ-027 Drive the scan of 1,2,3,4 (A..D) at 8 cycles per digit -> frame_done after the 4th digit settles, A=1 B=2 C=3 D=4, valid=1.
REQ-028 Hold each digit only 3 cycles with SETTLE=4 -> no sample, no frame_done, valid stays 0.
REQ-029 Send digit C=1111111 in an otherwise legal frame -> err=1 and A..D unchanged; the next good frame 5,6,7,8 -> err=0 and A..D=5,6,7,8.
REQ-030 Hold an=0011 for 20 cycles between digits -> no sample; the frame completes normally once legal strobes resume.
REQ-031 After a commit, drive an=1111 for TIMEOUT cycles -> valid falls exactly TIMEOUT cycles after frame_done while A..D hold their values.
REQ-032 Assert rst_n=0 after 2 of 4 digits -> all outputs 0; a later full frame commits only after 4 new samples.
